tma_perf_counter: RTL and testbench

TMA_PERF_COUNTER -- requirements
Module: tma_perf_counter

---
 rtl/tma_perf_counter.sv | 179 +++++++++++++++++
 tb/tb_tma_perf_counter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tma_perf_counter.sv
// tma_perf_counter: top-down microarchitecture analysis counters for a
// two-wide decoder. It classifies every decode slot as retiring work,
// backend stall, frontend starvation or bubble, and it tracks flushes and
// retirement. Counting stops when a HALT instruction is decoded. All counters
// can be read back through a one-cycle-latency read port.
module tma_perf_counter #(
   parameter int unsigned CNT_W         = 64,
   parameter logic [31:0] HALT_INST     = 32'h0000_006b,
   parameter int unsigned FLUSH_PENALTY = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec0_vld,
   input  logic [31:0]      dec0_inst,
   input  logic             dec1_vld,
   input  logic [31:0]      dec1_inst,
   input  logic             backend_stall,
   input  logic             flush_pipe,
   input  logic             retire0,
   input  logic             retire1,
   input  logic             clr,
   input  logic             rd_req,
   input  logic [3:0]       rd_addr,
   output logic             rd_ack,
   output logic [CNT_W-1:0] rd_data,
   output logic             halted
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Raw event counters
   logic [CNT_W-1:0] cnt_total;
   logic [CNT_W-1:0] cnt_inst;
   logic [CNT_W-1:0] cnt_bubble;
   logic [CNT_W-1:0] cnt_backend;
   logic [CNT_W-1:0] cnt_fe_raw;
   logic [CNT_W-1:0] cnt_retire;
   logic [CNT_W-1:0] cnt_flush;

   // Derived metrics
   logic [CNT_W-1:0] flush_rec;
   logic [CNT_W-1:0] fe_bound;
   logic [CNT_W-1:0] bad_spec;

   // Per-cycle increments
   logic [1:0] inc_inst_p0;
   logic [1:0] inc_bubble_p0;
   logic [1:0] inc_backend_p0;
   logic [1:0] inc_fe_p0;
   logic [1:0] inc_retire_p0;
   logic [1:0] inc_flush_p0;
   logic       halt_hit_p0;
   logic       count_en_p0;

   // Read path
   logic [CNT_W-1:0] rd_mux_p0;
   logic [CNT_W-1:0] rd_data_p1;
   logic             vld_p1;

   // Saturating add of a small increment; the counter sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
      sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // Subtraction clamped at zero for metrics that must not go negative.
   function automatic logic [CNT_W-1:0] clamp_sub(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
      clamp_sub = (a > b) ? (a - b) : '0;
   endfunction

   // ---- stage p0: classify this cycle's decode slots ----
   always_comb begin
      inc_inst_p0    = {1'b0, dec0_vld} + {1'b0, dec1_vld};
      inc_bubble_p0  = {1'b0, ~dec0_vld} + {1'b0, ~dec1_vld};
      inc_backend_p0 = {1'b0, dec0_vld & backend_stall}
                     + {1'b0, dec1_vld & backend_stall};
      inc_fe_p0      = {1'b0, dec0_vld & ~backend_stall}
                     + {1'b0, dec1_vld & ~backend_stall};
      inc_retire_p0  = {1'b0, retire0} + {1'b0, retire1};
      inc_flush_p0   = {1'b0, flush_pipe};
      halt_hit_p0    = (dec0_vld && (dec0_inst == HALT_INST))
                    || (dec1_vld && (dec1_inst == HALT_INST));
      count_en_p0    = (state_q == S_RUN) && !clr;
   end

   // Measurement-window state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   // Next state: clear always re-opens the window, a decoded HALT closes it
   always_comb begin
      state_d = state_q;
      if (clr)
         state_d = S_RUN;
      else if ((state_q == S_RUN) && halt_hit_p0)
         state_d = S_HALT;
   end

   assign halted = (state_q == S_HALT);

   // Event counters: clear wins, otherwise count only while the window is open
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_total   <= '0;
         cnt_inst    <= '0;
         cnt_bubble  <= '0;
         cnt_backend <= '0;
         cnt_fe_raw  <= '0;
         cnt_retire  <= '0;
         cnt_flush   <= '0;
      end else if (clr) begin
         cnt_total   <= '0;
         cnt_inst    <= '0;
         cnt_bubble  <= '0;
         cnt_backend <= '0;
         cnt_fe_raw  <= '0;
         cnt_retire  <= '0;
         cnt_flush   <= '0;
      end else if (count_en_p0) begin
         cnt_total   <= sat_add(cnt_total, 2'd2);
         cnt_inst    <= sat_add(cnt_inst, inc_inst_p0);
         cnt_bubble  <= sat_add(cnt_bubble, inc_bubble_p0);
         cnt_backend <= sat_add(cnt_backend, inc_backend_p0);
         cnt_fe_raw  <= sat_add(cnt_fe_raw, inc_fe_p0);
         cnt_retire  <= sat_add(cnt_retire, inc_retire_p0);
         cnt_flush   <= sat_add(cnt_flush, inc_flush_p0);
      end
   end

   // Flush recovery charges a fixed slot penalty per flush cycle; those slots
   // show up as starved frontend slots and are removed from frontend_bound.
   assign flush_rec = cnt_flush * CNT_W'(FLUSH_PENALTY);
   assign fe_bound  = clamp_sub(cnt_fe_raw, flush_rec);
   assign bad_spec  = clamp_sub(cnt_inst, cnt_retire);

   // Read select from the currently registered counter values
   always_comb begin
      rd_mux_p0 = '0;
      case (rd_addr)
         4'd0:    rd_mux_p0 = cnt_total;
         4'd1:    rd_mux_p0 = cnt_inst;
         4'd2:    rd_mux_p0 = cnt_bubble;
         4'd3:    rd_mux_p0 = cnt_backend;
         4'd4:    rd_mux_p0 = fe_bound;
         4'd5:    rd_mux_p0 = cnt_retire;
         4'd6:    rd_mux_p0 = bad_spec;
         4'd7:    rd_mux_p0 = flush_rec;
         4'd8:    rd_mux_p0 = cnt_flush;
         4'd9:    rd_mux_p0 = {{(CNT_W-1){1'b0}}, halted};
         default: rd_mux_p0 = '0;
      endcase
   end

   // ---- stage p1: registered read response, data held between requests ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         rd_data_p1 <= '0;
      end else begin
         vld_p1 <= rd_req;
         if (rd_req)
            rd_data_p1 <= rd_mux_p0;
      end
   end

   assign rd_ack  = vld_p1;
   assign rd_data = rd_data_p1;

endmodule

// File: tb/tb_tma_perf_counter.sv
// Testbench for tma_perf_counter: a reference model tracks the counters from
// the driven inputs, expected read values are queued at request time and
// compared when the acknowledge appears.
module tb_tma_perf_counter;

   localparam int W = 64;
   localparam logic [31:0] HALT = 32'h0000_006b;

   logic          clk = 1'b0;
   logic          rst_n, rst_n4;
   logic          dec0_vld, dec1_vld;
   logic [31:0]   dec0_inst, dec1_inst;
   logic          backend_stall, flush_pipe, retire0, retire1, clr;
   logic          rd_req, rd_req4;
   logic [3:0]    rd_addr, rd_addr4;
   logic          rd_ack, rd_ack4, halted, halted4;
   logic [W-1:0]  rd_data;
   logic [3:0]    rd_data4;

   always #5 clk = ~clk;

   tma_perf_counter #(.CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .dec0_vld(dec0_vld), .dec0_inst(dec0_inst),
      .dec1_vld(dec1_vld), .dec1_inst(dec1_inst),
      .backend_stall(backend_stall), .flush_pipe(flush_pipe),
      .retire0(retire0), .retire1(retire1), .clr(clr),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack), .rd_data(rd_data), .halted(halted)
   );

   tma_perf_counter #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n4),
      .dec0_vld(dec0_vld), .dec0_inst(dec0_inst),
      .dec1_vld(dec1_vld), .dec1_inst(dec1_inst),
      .backend_stall(backend_stall), .flush_pipe(flush_pipe),
      .retire0(retire0), .retire1(retire1), .clr(clr),
      .rd_req(rd_req4), .rd_addr(rd_addr4),
      .rd_ack(rd_ack4), .rd_data(rd_data4), .halted(halted4)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model
   logic [W-1:0] m_total, m_inst, m_bub, m_be, m_fraw, m_ret, m_flush;
   bit           m_halt;

   function automatic logic [W-1:0] sadd(input logic [W-1:0] a, input logic [W-1:0] inc);
      if (a > ({W{1'b1}} - inc)) return {W{1'b1}};
      return a + inc;
   endfunction

   function automatic logic [W-1:0] csub(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a > b) ? a - b : '0;
   endfunction

   function automatic logic [W-1:0] model_read(input int a);
      case (a)
         0: return m_total;
         1: return m_inst;
         2: return m_bub;
         3: return m_be;
         4: return csub(m_fraw, m_flush * 64'd8);
         5: return m_ret;
         6: return csub(m_inst, m_ret);
         7: return m_flush * 64'd8;
         8: return m_flush;
         9: return W'(m_halt);
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      m_total = 0; m_inst = 0; m_bub = 0; m_be = 0;
      m_fraw = 0; m_ret = 0; m_flush = 0; m_halt = 0;
   endtask

   task automatic model_update();
      int nv, nb, nbe, nfe, nr;
      if (clr) begin
         model_reset();
      end else if (!m_halt) begin
         nv  = int'(dec0_vld) + int'(dec1_vld);
         nb  = 2 - nv;
         nbe = backend_stall ? nv : 0;
         nfe = backend_stall ? 0 : nv;
         nr  = int'(retire0) + int'(retire1);
         m_total = sadd(m_total, 64'd2);
         m_inst  = sadd(m_inst, W'(nv));
         m_bub   = sadd(m_bub, W'(nb));
         m_be    = sadd(m_be, W'(nbe));
         m_fraw  = sadd(m_fraw, W'(nfe));
         m_ret   = sadd(m_ret, W'(nr));
         m_flush = sadd(m_flush, W'(flush_pipe));
         if ((dec0_vld && dec0_inst == HALT) || (dec1_vld && dec1_inst == HALT))
            m_halt = 1;
      end
   endtask

   // Scoreboard
   logic [W-1:0] exp_q[$];
   int           addr_q[$];
   bit           exp_given;
   logic [W-1:0] exp_val;

   task automatic idle();
      dec0_vld = 0; dec1_vld = 0; dec0_inst = 32'h13; dec1_inst = 32'h13;
      backend_stall = 0; flush_pipe = 0; retire0 = 0; retire1 = 0;
      clr = 0; rd_req = 0; rd_addr = 0; exp_given = 0;
   endtask

   task automatic step();
      if (rd_req) begin
         exp_q.push_back(exp_given ? exp_val : model_read(int'(rd_addr)));
         addr_q.push_back(int'(rd_addr));
      end
      @(posedge clk);
      if (rst_n) model_update();
      #1;
      exp_given = 0;
   endtask

   task automatic rd_exp(input int a, input logic [W-1:0] v);
      idle();
      rd_req = 1; rd_addr = 4'(a);
      exp_given = 1; exp_val = v;
      step();
   endtask

   // Response monitor on the falling edge
   logic [W-1:0] last_data;
   logic [W-1:0] mon_e;
   int           mon_a;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_data = '0;
      end else if (rd_ack) begin
         if (exp_q.size() == 0) begin
            chk("ack_unexpected", W'(rd_ack), '0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_a = addr_q.pop_front();
            chk($sformatf("rd_addr%0d", mon_a), rd_data, mon_e);
            last_data = rd_data;
         end
      end else begin
         chk("rd_hold", rd_data, last_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      model_reset();
      rst_n = 0; rst_n4 = 0; rd_req4 = 0; rd_addr4 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack", W'(rd_ack), '0);
      chk("reset_data", rd_data, '0);
      chk("reset_halted", W'(halted), '0);
      rst_n = 1;

      // Narrow instance: saturation and asynchronous reset
      rst_n4 = 1;
      repeat (8) step();
      rd_req4 = 1; rd_addr4 = 4'd0;
      step();
      chk("sat4_ack", W'(rd_ack4), 64'd1);
      chk("sat4_total", W'(rd_data4), 64'd15);
      rd_req4 = 0;
      repeat (4) step();
      rd_req4 = 1; rd_addr4 = 4'd2;
      step();
      chk("sat4_bubble", W'(rd_data4), 64'd15);
      rd_addr4 = 4'd0;
      step();
      #1 rst_n4 = 0;
      #1;
      chk("rst4_ack", W'(rd_ack4), '0);
      chk("rst4_data", W'(rd_data4), '0);
      chk("rst4_halted", W'(halted4), '0);
      rd_req4 = 0;

      // Full-width decode, halt on slot 1 in the tenth cycle
      idle(); clr = 1; step();
      for (int i = 0; i < 10; i++) begin
         idle();
         dec0_vld = 1; dec1_vld = 1; retire0 = 1; retire1 = 1;
         if (i == 9) dec1_inst = HALT;
         step();
         if (i == 8) chk("halted_before", W'(halted), '0);
      end
      chk("halted_set", W'(halted), 64'd1);
      for (int i = 0; i < 3; i++) begin
         idle(); dec0_vld = 1; dec1_vld = 1; flush_pipe = 1; retire0 = 1; step();
      end
      rd_exp(0, 64'd20);
      rd_exp(1, 64'd20);
      rd_exp(4, 64'd20);
      rd_exp(6, 64'd0);
      rd_exp(2, 64'd0);
      rd_exp(5, 64'd20);
      rd_exp(8, 64'd0);
      rd_exp(9, 64'd1);
      idle(); clr = 1; step();
      chk("halted_clr", W'(halted), '0);
      rd_exp(0, 64'd0);

      // Backend-stalled single-slot decode
      idle(); clr = 1; step();
      for (int i = 0; i < 4; i++) begin
         idle(); dec0_vld = 1; backend_stall = 1;
         if (i == 3) dec0_inst = HALT;
         step();
      end
      rd_exp(3, 64'd4);
      rd_exp(2, 64'd4);
      rd_exp(4, 64'd0);
      rd_exp(0, 64'd8);
      idle(); clr = 1; rd_req = 1; rd_addr = 4'd3;
      exp_given = 1; exp_val = 64'd4;
      step();
      rd_exp(3, 64'd0);

      // Flush recovery and frontend clamp
      idle(); clr = 1; step();
      for (int i = 0; i < 15; i++) begin
         idle(); dec0_vld = 1; dec1_vld = 1; step();
      end
      for (int i = 0; i < 2; i++) begin
         idle(); flush_pipe = 1; step();
      end
      rd_exp(8, 64'd2);
      rd_exp(7, 64'd16);
      rd_exp(4, 64'd14);
      rd_exp(6, 64'd30);
      for (int i = 0; i < 3; i++) begin
         idle(); flush_pipe = 1; step();
      end
      rd_exp(8, 64'd5);
      rd_exp(7, 64'd40);
      rd_exp(4, 64'd0);

      // Read coincident with an increment, unmapped address
      idle(); clr = 1; step();
      repeat (3) begin idle(); step(); end
      idle(); dec0_vld = 1; dec1_vld = 1; rd_req = 1; rd_addr = 4'd0;
      exp_given = 1; exp_val = 64'd6;
      step();
      rd_exp(0, 64'd8);
      rd_exp(12, 64'd0);

      // Random traffic with back-to-back reads, halting part-way
      for (int i = 0; i < 60; i++) begin
         idle();
         dec0_vld      = 1'($urandom_range(0, 1));
         dec1_vld      = 1'($urandom_range(0, 1));
         dec0_inst     = $urandom | 32'h100;
         dec1_inst     = $urandom | 32'h100;
         backend_stall = 1'($urandom_range(0, 1));
         flush_pipe    = ($urandom_range(0, 3) == 0);
         retire0       = 1'($urandom_range(0, 1));
         retire1       = 1'($urandom_range(0, 1));
         rd_req        = ($urandom_range(0, 9) < 7);
         rd_addr       = 4'($urandom_range(0, 15));
         if (i == 45) begin dec0_vld = 1; dec0_inst = HALT; end
         step();
      end

      // Asynchronous reset while a read response is pending
      idle(); rd_req = 1; rd_addr = 4'd0; step();
      #1 rst_n = 0;
      exp_q.delete();
      addr_q.delete();
      model_reset();
      #1;
      chk("rst_ack", W'(rd_ack), '0);
      chk("rst_data", rd_data, '0);
      chk("rst_halted", W'(halted), '0);
      idle();
      @(negedge clk);
      #1 rst_n = 1;
      step();
      rd_exp(0, 64'd2);
      rd_exp(9, 64'd0);

      idle();
      repeat (2) step();
      chk("pending_acks", W'(exp_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
